// File: rtl/interrupt_acknowledge_sequencer_pkg.sv
// interrupt_acknowledge_sequencer_pkg: shared FSM states, level type and fixed-priority encoder
package interrupt_acknowledge_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, ACK1, WAIT2, ACK2} state_t;
  typedef logic [2:0] level_t;
  typedef struct packed {
    logic   valid;
    level_t level;
  } prio_t;
  function automatic prio_t prio_encode(input logic [7:0] v);
    prio_t r;
    r.valid = 1'b0;
    r.level = '0;
    for (int i = 7; i >= 0; i--)
      if (v[i]) begin
        r.valid = 1'b1;
        r.level = level_t'(i);
      end
    return r;
  endfunction
endpackage

// File: rtl/interrupt_acknowledge_sequencer_if.sv
// interrupt_acknowledge_sequencer_if: request/mask/config inputs, INTA pin, INT/ISR/vector outputs
interface interrupt_acknowledge_sequencer_if;
  logic [7:0] interrupt_request_register;
  logic [7:0] interrupt_mask;
  logic       interrupt_acknowledge_n;
  logic       auto_eoi_config;
  logic [4:0] interrupt_vector_address;
  logic       end_of_interrupt;
  logic       specific_eoi;
  logic [2:0] eoi_level;
  logic       interrupt_to_cpu;
  logic       freeze;
  logic [7:0] clear_interrupt_request;
  logic [7:0] in_service_register;
  logic [7:0] data_bus_out;
  logic       data_bus_out_enable;
  modport master (
    output interrupt_request_register, interrupt_mask, interrupt_acknowledge_n, auto_eoi_config,
           interrupt_vector_address, end_of_interrupt, specific_eoi, eoi_level,
    input  interrupt_to_cpu, freeze, clear_interrupt_request, in_service_register,
           data_bus_out, data_bus_out_enable
  );
  modport slave (
    input  interrupt_request_register, interrupt_mask, interrupt_acknowledge_n, auto_eoi_config,
           interrupt_vector_address, end_of_interrupt, specific_eoi, eoi_level,
    output interrupt_to_cpu, freeze, clear_interrupt_request, in_service_register,
           data_bus_out, data_bus_out_enable
  );
endinterface

// File: rtl/interrupt_acknowledge_sequencer_priority_resolver.sv
// interrupt_acknowledge_sequencer_priority_resolver: lowest eligible level, valid only if above every in-service level
module interrupt_acknowledge_sequencer_priority_resolver
  import interrupt_acknowledge_sequencer_pkg::*;
(
  input  logic [7:0] eligible,
  input  logic [7:0] isr,
  output level_t     level,
  output logic       valid
);
  prio_t c, s;
  assign c = prio_encode(eligible);
  assign s = prio_encode(isr);
  assign level = c.level;
  assign valid = c.valid & (~s.valid | (c.level < s.level));
endmodule

// File: rtl/interrupt_acknowledge_sequencer.sv
// interrupt_acknowledge_sequencer: raises INT, runs the two-pulse 8086 INTA sequence, maintains ISR and EOI
module interrupt_acknowledge_sequencer
  import interrupt_acknowledge_sequencer_pkg::*;
#(
  parameter int INTA_TIMEOUT   = 16,
  parameter int SPURIOUS_LEVEL = 7
) (
  input logic clock,
  input logic reset,
  interrupt_acknowledge_sequencer_if.slave bus
);
  localparam int CW = $clog2(INTA_TIMEOUT) + 1;
  state_t        state_q, state_d;
  level_t        level_q, level_d, cand;
  logic          spur_q, spur_d, prev_q, int_q, int_d, freeze_q, freeze_d, oe_q, oe_d;
  logic          valid, fall, rise, load_vec;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    isr_q, isr_d, clear_q, dout_q, dout_d, set_v, aeoi_v, eoi_v;
  interrupt_acknowledge_sequencer_priority_resolver u_res (
    .eligible(bus.interrupt_request_register & ~bus.interrupt_mask),
    .isr     (isr_q),
    .level   (cand),
    .valid   (valid)
  );
  assign fall = prev_q & ~bus.interrupt_acknowledge_n;
  assign rise = ~prev_q & bus.interrupt_acknowledge_n;
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    spur_d   = spur_q;
    cnt_d    = '0;
    load_vec = 1'b0;
    set_v    = '0;
    aeoi_v   = '0;
    case (state_q)
      IDLE: if (fall) begin
        state_d = ACK1;
        level_d = valid ? cand : level_t'(SPURIOUS_LEVEL);
        spur_d  = ~valid;
        set_v   = valid ? 8'd1 << cand : '0;
      end
      ACK1: if (rise) state_d = WAIT2;
      WAIT2: begin
        cnt_d = cnt_q + CW'(1);
        if (fall) begin
          state_d  = ACK2;
          load_vec = 1'b1;
        end else if (cnt_q == CW'(INTA_TIMEOUT - 1)) state_d = IDLE;
      end
      ACK2: if (rise) begin
        state_d = IDLE;
        aeoi_v  = (bus.auto_eoi_config & ~spur_q) ? 8'd1 << level_q : '0;
      end
      default: state_d = IDLE;
    endcase
    // isr & -isr isolates the lowest set bit for non-specific EOI; set is OR'd last so it wins
    eoi_v    = bus.end_of_interrupt ? (bus.specific_eoi ? 8'd1 << bus.eoi_level : isr_q & (~isr_q + 8'd1)) : '0;
    isr_d    = (isr_q & ~(eoi_v | aeoi_v)) | set_v;
    int_d    = (state_q == IDLE) ? valid : (state_q == ACK1 && !rise) ? int_q : 1'b0;
    freeze_d = state_d != IDLE;
    oe_d     = state_d == ACK2;
    dout_d   = load_vec ? {bus.interrupt_vector_address, level_q} : (state_d == ACK2 ? dout_q : '0);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      level_q  <= '0;
      spur_q   <= 1'b0;
      cnt_q    <= '0;
      prev_q   <= 1'b1;
      int_q    <= 1'b0;
      freeze_q <= 1'b0;
      oe_q     <= 1'b0;
      isr_q    <= '0;
      clear_q  <= '0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      spur_q   <= spur_d;
      cnt_q    <= cnt_d;
      prev_q   <= bus.interrupt_acknowledge_n;
      int_q    <= int_d;
      freeze_q <= freeze_d;
      oe_q     <= oe_d;
      isr_q    <= isr_d;
      clear_q  <= set_v;
      dout_q   <= dout_d;
    end
  end
  assign bus.interrupt_to_cpu        = int_q;
  assign bus.freeze                  = freeze_q;
  assign bus.clear_interrupt_request = clear_q;
  assign bus.in_service_register     = isr_q;
  assign bus.data_bus_out            = dout_q;
  assign bus.data_bus_out_enable     = oe_q;
endmodule

// File: tb/tb_interrupt_acknowledge_sequencer.sv
// tb_interrupt_acknowledge_sequencer: directed INTA/EOI sequences with hand-computed expectations
module tb_interrupt_acknowledge_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  logic oe_seen;
  interrupt_acknowledge_sequencer_if bus ();
  interrupt_acknowledge_sequencer dut (.clock(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic inta(input logic v);
    bus.interrupt_acknowledge_n = v;
    step();
  endtask
  task automatic full_ack();
    inta(1'b0); inta(1'b0); inta(1'b1); inta(1'b1); inta(1'b0); inta(1'b1);
  endtask
  task automatic eoi(input logic spec, input logic [2:0] lvl);
    bus.end_of_interrupt = 1'b1;
    bus.specific_eoi     = spec;
    bus.eoi_level        = lvl;
    step();
    bus.end_of_interrupt = 1'b0;
  endtask
  initial begin
    bus.interrupt_request_register = '0;
    bus.interrupt_mask             = '0;
    bus.interrupt_acknowledge_n    = 1'b1;
    bus.auto_eoi_config            = 1'b0;
    bus.interrupt_vector_address   = 5'h08;
    bus.end_of_interrupt           = 1'b0;
    bus.specific_eoi               = 1'b0;
    bus.eoi_level                  = '0;
    step(2);
    rst = 1'b0;
    step();
    chk("rst_int", {7'd0, bus.interrupt_to_cpu}, 8'h00);
    chk("rst_freeze", {7'd0, bus.freeze}, 8'h00);
    chk("rst_isr", bus.in_service_register, 8'h00);
    chk("rst_oe", {7'd0, bus.data_bus_out_enable}, 8'h00);
    // basic acknowledge of IR2 out of 0x24
    bus.interrupt_request_register = 8'h24;
    step();
    chk("t1_int", {7'd0, bus.interrupt_to_cpu}, 8'h01);
    inta(1'b0);
    chk("t1_isr_set", bus.in_service_register, 8'h04);
    chk("t1_clear", bus.clear_interrupt_request, 8'h04);
    chk("t1_freeze", {7'd0, bus.freeze}, 8'h01);
    bus.interrupt_request_register = 8'h20;
    inta(1'b0);
    chk("t1_clear_1cyc", bus.clear_interrupt_request, 8'h00);
    inta(1'b1);
    chk("t1_int_wait2", {7'd0, bus.interrupt_to_cpu}, 8'h00);
    inta(1'b1);
    inta(1'b0);
    chk("t1_vector", bus.data_bus_out, 8'h42);
    chk("t1_oe", {7'd0, bus.data_bus_out_enable}, 8'h01);
    inta(1'b1);
    chk("t1_freeze_off", {7'd0, bus.freeze}, 8'h00);
    chk("t1_oe_off", {7'd0, bus.data_bus_out_enable}, 8'h00);
    chk("t1_isr_kept", bus.in_service_register, 8'h04);
    step();
    chk("t1_int_nested", {7'd0, bus.interrupt_to_cpu}, 8'h00);
    // AEOI variant
    bus.interrupt_request_register = 8'h00;
    eoi(1'b1, 3'd2);
    chk("t2_eoi_spec", bus.in_service_register, 8'h00);
    bus.auto_eoi_config = 1'b1;
    bus.interrupt_request_register = 8'h24;
    step();
    full_ack();
    chk("t2_aeoi_isr", bus.in_service_register, 8'h00);
    bus.interrupt_request_register = 8'h00;
    bus.auto_eoi_config = 1'b0;
    eoi(1'b0, 3'd0);
    chk("t2_eoi_noop", bus.in_service_register, 8'h00);
    // nesting: ISR=0x02 blocks IR3, admits IR0
    bus.interrupt_request_register = 8'h02;
    step();
    full_ack();
    chk("t3_isr02", bus.in_service_register, 8'h02);
    bus.interrupt_request_register = 8'h08;
    step(2);
    chk("t3_int_blocked", {7'd0, bus.interrupt_to_cpu}, 8'h00);
    bus.interrupt_request_register = 8'h01;
    step();
    chk("t3_int_ir0", {7'd0, bus.interrupt_to_cpu}, 8'h01);
    full_ack();
    chk("t3_isr03", bus.in_service_register, 8'h03);
    // withdrawn request gives spurious level 7
    bus.interrupt_request_register = 8'h00;
    eoi(1'b0, 3'd0);
    chk("t4_eoi_ns1", bus.in_service_register, 8'h02);
    eoi(1'b0, 3'd0);
    chk("t4_eoi_ns2", bus.in_service_register, 8'h00);
    bus.interrupt_request_register = 8'h10;
    step();
    chk("t4_int", {7'd0, bus.interrupt_to_cpu}, 8'h01);
    bus.interrupt_request_register = 8'h00;
    inta(1'b0);
    chk("t4_isr_none", bus.in_service_register, 8'h00);
    chk("t4_no_clear", bus.clear_interrupt_request, 8'h00);
    chk("t4_freeze", {7'd0, bus.freeze}, 8'h01);
    inta(1'b1);
    inta(1'b0);
    chk("t4_vector", bus.data_bus_out, 8'h47);
    inta(1'b1);
    chk("t4_isr_after", bus.in_service_register, 8'h00);
    // second pulse never arrives
    bus.interrupt_request_register = 8'h01;
    step();
    inta(1'b0);
    bus.interrupt_request_register = 8'h00;
    inta(1'b1);
    oe_seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      oe_seen |= bus.data_bus_out_enable;
    end
    chk("t5_freeze_15", {7'd0, bus.freeze}, 8'h01);
    step();
    oe_seen |= bus.data_bus_out_enable;
    chk("t5_freeze_16", {7'd0, bus.freeze}, 8'h00);
    chk("t5_oe_never", {7'd0, oe_seen}, 8'h00);
    chk("t5_isr_kept", bus.in_service_register, 8'h01);
    // reset during ACK2
    eoi(1'b0, 3'd0);
    bus.interrupt_request_register = 8'h04;
    step();
    inta(1'b0); inta(1'b1); inta(1'b0);
    chk("t6_oe", {7'd0, bus.data_bus_out_enable}, 8'h01);
    rst = 1'b1;
    step();
    chk("t6_int", {7'd0, bus.interrupt_to_cpu}, 8'h00);
    chk("t6_freeze", {7'd0, bus.freeze}, 8'h00);
    chk("t6_isr", bus.in_service_register, 8'h00);
    chk("t6_dout", bus.data_bus_out, 8'h00);
    chk("t6_oe_off", {7'd0, bus.data_bus_out_enable}, 8'h00);
    bus.interrupt_acknowledge_n = 1'b1;
    bus.interrupt_request_register = 8'h00;
    step();
    rst = 1'b0;
    step();
    // specific EOI level 3 coincident with AEOI of level 1
    bus.interrupt_request_register = 8'h08;
    step();
    full_ack();
    chk("t7_isr08", bus.in_service_register, 8'h08);
    bus.auto_eoi_config = 1'b1;
    bus.interrupt_request_register = 8'h02;
    step();
    inta(1'b0);
    chk("t7_isr0a", bus.in_service_register, 8'h0A);
    bus.interrupt_request_register = 8'h00;
    inta(1'b1);
    inta(1'b0);
    chk("t7_vector", bus.data_bus_out, 8'h41);
    bus.end_of_interrupt = 1'b1;
    bus.specific_eoi     = 1'b1;
    bus.eoi_level        = 3'd3;
    inta(1'b1);
    bus.end_of_interrupt = 1'b0;
    chk("t7_isr_union", bus.in_service_register, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
